// File: rtl/bus_arbiter.sv
// Round-robin arbiter handing a shared unidirectional tristate bus to one of N
// requesters, with a forced all-off turnaround cycle between owners.
module bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         cnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int         W        = $clog2(N);
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t         state_reg;
    logic [W-1:0]   ptr_reg;
    logic [W-1:0]   owner_reg;
    logic [7:0]     hcnt_reg;
    logic [N-1:0]   gnt_reg;
    logic           busy_reg;

    logic [W-1:0]   cand;
    logic [W-1:0]   sel_idx;
    logic [N-1:0]   sel_onehot;
    logic           others_req;
    logic           release_now;
    logic [W-1:0]   ptr_next;

    // Walk the rotation from the far end back toward ptr so the closest set bit wins.
    always_comb begin
        cand    = '0;
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = W'((int'(ptr_reg) + i) % N);
            if (req[cand]) begin
                sel_idx = cand;
            end
        end
    end

    assign sel_onehot  = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    assign others_req  = |(req & ~gnt_reg);
    assign release_now = !req[owner_reg] || ((hcnt_reg == HOLD_MAX) && others_req);
    assign ptr_next    = (owner_reg == W'(N - 1)) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            hcnt_reg  <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                // The turnaround cycle arbitrates exactly like idle; only its entry differs.
                IDLE, TURN: begin
                    if (|req) begin
                        gnt_reg   <= sel_onehot;
                        owner_reg <= sel_idx;
                        busy_reg  <= 1'b1;
                        hcnt_reg  <= 8'd1;
                        state_reg <= GRANT;
                    end else begin
                        gnt_reg   <= '0;
                        owner_reg <= '0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_reg   <= '0;
                        owner_reg <= '0;
                        busy_reg  <= 1'b0;
                        ptr_reg   <= ptr_next;
                        state_reg <= TURN;
                    end else if (hcnt_reg != HOLD_MAX) begin
                        hcnt_reg <= hcnt_reg + 8'd1;
                    end
                end
                default: begin
                    gnt_reg   <= '0;
                    owner_reg <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt   = gnt_reg;
    assign owner = owner_reg;
    assign busy  = busy_reg;

    // Each buffer enable follows its grant bit directly.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cnt
            assign cnt[gi] = gnt_reg[gi];
        end
    endgenerate
endmodule
